set_button_ctrl: RTL and testbench

- Upstream stage of the clock time register; turns two raw, asynchronous, bouncing push-buttons into clean set controls.
- Outputs: set-hours level, set-minutes level, and a one-cycle set strobe with hold-to-repeat.
- The downstream register consumes all three outputs directly. Both levels high means "zero seconds" downstream.
- Timing runs on a slow timebase strobe (nominally 1 kHz) from the existing clock divider.

---
 rtl/set_button_ctrl.sv | 142 ++++++++++++++
 tb/tb_set_button_ctrl.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/set_button_ctrl.sv
// rtl/set_button_ctrl.sv - debounced set-hours/set-minutes levels and set strobe with hold-to-repeat
// Optional macro SET_BUTTON_ACCEL_EN: repeat period drops to a quarter after 8 repeat-state strobes.
module set_button_ctrl #(
  parameter int DEBOUNCE_TICKS      = 20,
  parameter int REPEAT_DELAY_TICKS  = 500,
  parameter int REPEAT_PERIOD_TICKS = 200,
  parameter int CNT_W               = 10
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_tick_stb,
  input  logic i_btn_hours,
  input  logic i_btn_minutes,
  output logic o_set_hours,
  output logic o_set_minutes,
  output logic o_set_stb
);

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_TICKS - 1);
  localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY_TICKS - 1);
  localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PERIOD_TICKS - 1);
`ifdef SET_BUTTON_ACCEL_EN
  localparam int               ACC_PER  = (REPEAT_PERIOD_TICKS / 4 < 1) ? 1 : REPEAT_PERIOD_TICKS / 4;
  localparam logic [CNT_W-1:0] ACC_LAST = CNT_W'(ACC_PER - 1);
`endif

  typedef enum logic [1:0] {S_IDLE, S_DELAY, S_REPEAT} state_t;

  // Bit 1 carries the hours button, bit 0 the minutes button throughout.
  logic [1:0]       r_meta;
  logic [1:0]       r_sync;
  logic [1:0]       r_db;
  logic [CNT_W-1:0] r_db_cnt [2];

  state_t           r_state;
  logic [1:0]       r_combo;
  logic [CNT_W-1:0] r_rpt_cnt;
  logic             r_stb;
  logic [CNT_W-1:0] w_limit;
`ifdef SET_BUTTON_ACCEL_EN
  logic [3:0]       r_accel;
`endif

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_meta <= 2'b00;
      r_sync <= 2'b00;
    end else begin
      r_meta <= {i_btn_hours, i_btn_minutes};
      r_sync <= r_meta;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_db <= 2'b00;
      for (int b = 0; b < 2; b++) r_db_cnt[b] <= '0;
    end else begin
      for (int b = 0; b < 2; b++) begin
        if (r_sync[b] == r_db[b]) begin
          r_db_cnt[b] <= '0;
        end else if (i_tick_stb) begin
          if (r_db_cnt[b] == DEB_LAST) begin
            r_db[b]     <= r_sync[b];
            r_db_cnt[b] <= '0;
          end else begin
            r_db_cnt[b] <= r_db_cnt[b] + CNT_W'(1);
          end
        end
      end
    end
  end

`ifdef SET_BUTTON_ACCEL_EN
  assign w_limit = (r_state == S_DELAY) ? DLY_LAST : ((r_accel >= 4'd8) ? ACC_LAST : PER_LAST);
`else
  assign w_limit = (r_state == S_DELAY) ? DLY_LAST : PER_LAST;
`endif

  // A strobe that would follow a strobe directly is held off one cycle; the cause stays pending.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state   <= S_IDLE;
      r_combo   <= 2'b00;
      r_rpt_cnt <= '0;
      r_stb     <= 1'b0;
`ifdef SET_BUTTON_ACCEL_EN
      r_accel   <= 4'd0;
`endif
    end else begin
      r_stb <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (r_db != 2'b00 && !r_stb) begin
            r_stb     <= 1'b1;
            r_combo   <= r_db;
            r_rpt_cnt <= '0;
            r_state   <= S_DELAY;
          end
        end
        default: begin
          if (r_db == 2'b00) begin
            r_state   <= S_IDLE;
            r_combo   <= 2'b00;
            r_rpt_cnt <= '0;
`ifdef SET_BUTTON_ACCEL_EN
            r_accel   <= 4'd0;
`endif
          end else if (r_db != r_combo) begin
            if (!r_stb) begin
              r_stb     <= 1'b1;
              r_combo   <= r_db;
              r_rpt_cnt <= '0;
              r_state   <= S_DELAY;
`ifdef SET_BUTTON_ACCEL_EN
              r_accel   <= 4'd0;
`endif
            end
          end else if (i_tick_stb) begin
            if (r_rpt_cnt >= w_limit) begin
              if (!r_stb) begin
                r_stb     <= 1'b1;
                r_rpt_cnt <= '0;
                r_state   <= S_REPEAT;
`ifdef SET_BUTTON_ACCEL_EN
                if (r_state == S_REPEAT && r_accel != 4'd15) r_accel <= r_accel + 4'd1;
`endif
              end
            end else begin
              r_rpt_cnt <= r_rpt_cnt + CNT_W'(1);
            end
          end
        end
      endcase
    end
  end

  assign o_set_hours   = r_db[1];
  assign o_set_minutes = r_db[0];
  assign o_set_stb     = r_stb;

endmodule

// File: tb/tb_set_button_ctrl.sv
// tb/tb_set_button_ctrl.sv - randomized and directed bench for set_button_ctrl against a behavioural model
module tb_set_button_ctrl;
  localparam int DEB  = 20;
  localparam int DLY  = 500;
  localparam int PER  = 200;
  localparam int APER = (PER / 4 < 1) ? 1 : PER / 4;
`ifdef SET_BUTTON_ACCEL_EN
  localparam bit ACC = 1'b1;
`else
  localparam bit ACC = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tick = 1'b0;
  logic btn_h = 1'b0;
  logic btn_m = 1'b0;
  logic o_set_hours, o_set_minutes, o_set_stb;

  int errors = 0;
  int checks = 0;
  int tick_count = 0;
  int tick_mode = 0;
  int q_stb[$];
  bit prev_stb = 1'b0;

  set_button_ctrl dut (
    .i_clk        (clk),
    .i_reset_n    (rst_n),
    .i_tick_stb   (tick),
    .i_btn_hours  (btn_h),
    .i_btn_minutes(btn_m),
    .o_set_hours  (o_set_hours),
    .o_set_minutes(o_set_minutes),
    .o_set_stb    (o_set_stb)
  );

  always #5 clk = ~clk;

  // Timebase: alternate cycles, continuous, or sparse random.
  initial forever begin
    @(posedge clk);
    #2;
    case (tick_mode)
      0:       tick = ~tick;
      1:       tick = 1'b1;
      default: tick = ($urandom_range(0, 3) == 0);
    endcase
  end

  // Behavioural model: buttons are "pressed" once a synchronized level has differed from the
  // accepted level for DEB timebase ticks; strobes are due DLY ticks after a press and PER apart after.
  logic [1:0] m_s1, m_s2, m_db, m_combo, db_old, s2_old;
  int  m_run [2];
  bit  m_held, m_stb, stb_old;
  int  m_ticks, m_reps, due;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_s1 = 2'b00; m_s2 = 2'b00; m_db = 2'b00; m_combo = 2'b00;
      m_run[0] = 0; m_run[1] = 0;
      m_held = 1'b0; m_stb = 1'b0; m_ticks = 0; m_reps = 0;
    end else begin
      if (tick) tick_count++;
      db_old = m_db; s2_old = m_s2; stb_old = m_stb;
      m_s2 = m_s1;
      m_s1 = {btn_h, btn_m};
      for (int b = 0; b < 2; b++) begin
        if (s2_old[b] == db_old[b]) m_run[b] = 0;
        else if (tick) begin
          if (m_run[b] + 1 == DEB) begin m_db[b] = s2_old[b]; m_run[b] = 0; end
          else m_run[b]++;
        end
      end
      m_stb = 1'b0;
      if (!m_held) begin
        if (db_old != 2'b00 && !stb_old) begin
          m_stb = 1'b1; m_held = 1'b1; m_combo = db_old; m_ticks = 0; m_reps = 0;
        end
      end else if (db_old == 2'b00) begin
        m_held = 1'b0; m_ticks = 0; m_reps = 0;
      end else if (db_old != m_combo) begin
        if (!stb_old) begin m_stb = 1'b1; m_combo = db_old; m_ticks = 0; m_reps = 0; end
      end else if (tick) begin
        due = (m_reps == 0) ? DLY : ((ACC && m_reps >= 9) ? APER : PER);
        if (m_ticks + 1 >= due) begin
          if (!stb_old) begin m_stb = 1'b1; m_ticks = 0; m_reps++; end
        end else m_ticks++;
      end
    end
  end

  always @(negedge clk) begin
    checks++;
    if (o_set_hours !== m_db[1] || o_set_minutes !== m_db[0] || o_set_stb !== m_stb) begin
      errors++;
      if (errors < 20)
        $display("FAIL cycle_compare t=%0t: got h=%b m=%b stb=%b, expected h=%b m=%b stb=%b",
                 $time, o_set_hours, o_set_minutes, o_set_stb, m_db[1], m_db[0], m_stb);
    end
    checks++;
    if (o_set_stb === 1'b1 && prev_stb) begin
      errors++;
      if (errors < 20) $display("FAIL no_back_to_back t=%0t: got two strobes, expected one", $time);
    end
    prev_stb = (o_set_stb === 1'b1);
    if (o_set_stb === 1'b1) q_stb.push_back(tick_count);
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_rng(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #3;
  endtask

  task automatic wait_ticks(input int n);
    int s, g;
    s = tick_count;
    g = 0;
    while (tick_count - s < n && g < n * 8 + 100) begin step(); g++; end
  endtask

  task automatic wait_hours(input logic v, input string name, output int stamp);
    int g;
    g = 0;
    while (o_set_hours !== v && g < 4000) begin step(); g++; end
    stamp = tick_count;
    if (g >= 4000) chk({name, "_timeout"}, 0, 1);
  endtask

  task automatic settle();
    btn_h = 1'b0; btn_m = 1'b0;
    tick_mode = 0;
    wait_ticks(40);
    q_stb.delete();
  endtask

  int t_edge, t_rise, n0, nexp;

  initial begin
    repeat (3) step();
    chk("reset_hours", o_set_hours, 0);
    chk("reset_minutes", o_set_minutes, 0);
    chk("reset_stb", o_set_stb, 0);
    rst_n = 1'b1;
    settle();

    // Bounce: toggle every 5 ticks for 100 ticks, final edge high.
    for (int i = 0; i <= 20; i++) begin
      btn_h = (i % 2 == 0);
      t_edge = tick_count;
      if (i < 20) wait_ticks(5);
    end
    wait_hours(1'b1, "bounce_rise", t_rise);
    chk_rng("bounce_rise_ticks", t_rise - t_edge, DEB, DEB + 1);
    wait_ticks(10);
    chk("bounce_strobes", q_stb.size(), 1);
    chk("bounce_minutes_low", o_set_minutes, 0);
    settle();

    // Hold minutes: strobes at 0, 500, 700 ... 1500 ticks.
    btn_m = 1'b1;
    n0 = 0;
    while (q_stb.size() == 0 && n0 < 2000) begin step(); n0++; end
    if (n0 >= 2000) chk("hold_first_timeout", 0, 1);
    wait_ticks(1505);
    btn_m = 1'b0;
    wait_ticks(300);
    chk("hold_strobes", q_stb.size(), 7);
    for (int i = 1; i < q_stb.size(); i++)
      chk($sformatf("hold_gap%0d", i), q_stb[i] - q_stb[i-1], (i == 1) ? DLY : PER);
    settle();

    // Short press.
    btn_m = 1'b1;
    wait_ticks(30);
    btn_m = 1'b0;
    wait_ticks(22);
    chk("short_strobes", q_stb.size(), 1);
    chk("short_minutes_low", o_set_minutes, 0);
    chk("short_hours_low", o_set_hours, 0);
    settle();

    // Combo: hours, then minutes 100 ticks later.
    btn_h = 1'b1;
    wait_ticks(100);
    btn_m = 1'b1;
    wait_ticks(650);
    chk("combo_both_high", {o_set_hours, o_set_minutes}, 3);
    btn_h = 1'b0; btn_m = 1'b0;
    wait_ticks(30);
    chk("combo_strobes", q_stb.size(), 3);
    if (q_stb.size() == 3) begin
      chk_rng("combo_gap1", q_stb[1] - q_stb[0], 99, 101);
      chk("combo_gap2", q_stb[2] - q_stb[1], DLY);
    end
    settle();

    // Reset mid-hold while repeating.
    btn_h = 1'b1;
    wait_ticks(800);
    rst_n = 1'b0;
    #1;
    chk("midreset_hours", o_set_hours, 0);
    chk("midreset_stb", o_set_stb, 0);
    repeat (3) step();
    rst_n = 1'b1;
    q_stb.delete();
    t_edge = tick_count;
    wait_hours(1'b1, "midreset_rise", t_rise);
    chk_rng("midreset_rise_ticks", t_rise - t_edge, DEB, DEB + 1);
    wait_ticks(30);
    chk("midreset_strobes", q_stb.size(), 1);
    settle();

    // Long hold: repeat spacing with and without acceleration.
    btn_h = 1'b1;
    n0 = 0;
    while (q_stb.size() == 0 && n0 < 2000) begin step(); n0++; end
    wait_ticks(3000);
    btn_h = 1'b0;
    wait_ticks(30);
`ifndef SET_BUTTON_ACCEL_EN
    chk("long_strobes", q_stb.size(), 14);
`endif
    for (int i = 1; i < q_stb.size(); i++) begin
      nexp = (i == 1) ? 500 : ((ACC && i >= 10) ? 50 : 200);
      chk($sformatf("long_gap%0d", i), q_stb[i] - q_stb[i-1], nexp);
    end
    settle();

    // Randomized traffic, including continuous ticks and the occasional reset.
    for (int s = 0; s < 40; s++) begin
      tick_mode = $urandom_range(0, 2);
      n0 = $urandom_range(0, 9);
      btn_h = $urandom_range(0, 1);
      btn_m = $urandom_range(0, 1);
      if (n0 < 3) begin
        repeat ($urandom_range(1, 40)) step();
      end else if (n0 == 9) begin
        repeat ($urandom_range(50, 300)) step();
        rst_n = 1'b0;
        repeat ($urandom_range(1, 3)) step();
        rst_n = 1'b1;
      end else begin
        repeat ($urandom_range(20, 700)) step();
      end
    end
    btn_h = 1'b0; btn_m = 1'b0;
    tick_mode = 1;
    repeat (100) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
